sitcpxg_tx_arbiter: RTL and testbench

Round-robin scheduler that shares the single SiTCPXG TCP transmit port (USER_TX_D / USER_TX_B / USER_TX_AFULL) among NCH user data channels. It sits between the per-channel user data producers and the SiTCPXG core. All logic runs in the XGMII_CLOCK domain. Each grant is framed by one 8-byte header word so the host can demultiplex the TCP byte stream.

---
 rtl/sitcpxg_tx_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_sitcpxg_tx_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sitcpxg_tx_arbiter.sv
// rtl/sitcpxg_tx_arbiter.sv - round-robin scheduler sharing the SiTCPXG TCP transmit port among NCH user channels
module sitcpxg_tx_arbiter #(
    parameter int NCH         = 4,
    parameter int BURST_WORDS = 64
) (
    input  logic                XGMII_CLOCK,
    input  logic                RSTs,
    input  logic                USER_SESSION_ESTABLISHED,
    input  logic                USER_TX_AFULL,
    output logic [63:0]         USER_TX_D,
    output logic [3:0]          USER_TX_B,
    input  logic [NCH-1:0]      REQ_VALID,
    input  logic [NCH*64-1:0]   REQ_D,
    input  logic [NCH*4-1:0]    REQ_B,
    input  logic [NCH-1:0]      REQ_LAST,
    output logic [NCH-1:0]      REQ_READY,
    output logic [3:0]          GRANT_CH,
    output logic                BUSY
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic [16:0] C_BURST = 17'(BURST_WORDS);
    localparam logic [4:0]  C_NCH   = 5'(NCH);
    localparam logic [3:0]  C_LAST  = 4'(NCH - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [3:0]     r_ptr;
    logic [3:0]     r_grant;
    logic [16:0]    r_wcnt;
    logic [31:0]    r_seq [NCH];
    logic [63:0]    r_tx_d;
    logic [3:0]     r_tx_b;

    logic [2*NCH-1:0] w_req_dbl;
    logic [NCH-1:0]   w_req_rot;
    logic [4:0]       w_offset;
    logic [4:0]       w_pick_sum;
    logic [3:0]       w_pick;

    logic           w_g_valid;
    logic           w_g_last;
    logic [63:0]    w_g_d;
    logic [3:0]     w_g_b;
    logic [31:0]    w_g_seq;
    logic [3:0]     w_b_clamp;
    logic [16:0]    w_wcnt_inc;
    logic [3:0]     w_ptr_nxt;
    logic [63:0]    w_hdr;

    logic           w_grant_en;
    logic           w_emit_hdr;
    logic           w_rdy_g;
    logic           w_hs;
    logic           w_burst_end;

    // Rotate the request vector so bit 0 is the channel at PTR; the lowest set bit is the winner.
    assign w_req_dbl = {REQ_VALID, REQ_VALID} >> r_ptr;
    assign w_req_rot = w_req_dbl[NCH-1:0];

    // Priority pick of the first valid request at or after PTR.
    always_comb begin
        w_offset = 5'd0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_offset = 5'(k);
            end
        end
    end

    assign w_pick_sum = {1'b0, r_ptr} + w_offset;
    assign w_pick     = (w_pick_sum >= C_NCH) ? 4'(w_pick_sum - C_NCH) : w_pick_sum[3:0];

    // Select the request signals and sequence counter of the granted channel.
    always_comb begin
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        w_g_d     = 64'd0;
        w_g_b     = 4'd0;
        w_g_seq   = 32'd0;
        for (int j = 0; j < NCH; j++) begin
            if (r_grant == 4'(j)) begin
                w_g_valid = REQ_VALID[j];
                w_g_last  = REQ_LAST[j];
                w_g_d     = REQ_D[j*64 +: 64];
                w_g_b     = REQ_B[j*4 +: 4];
                w_g_seq   = r_seq[j];
            end
        end
    end

    // Byte counts above 8 cannot describe a 64-bit word, so they saturate.
    assign w_b_clamp  = (w_g_b > 4'd8) ? 4'd8 : w_g_b;
    assign w_wcnt_inc = r_wcnt + 17'd1;
    assign w_ptr_nxt  = (r_grant == C_LAST) ? 4'd0 : r_grant + 4'd1;
    assign w_hdr      = {8'hC3, 4'h0, r_grant, 16'h0000, w_g_seq};

    // Next-state and per-cycle control decode; a closed session forces IDLE from any state.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_en  = 1'b0;
        w_emit_hdr  = 1'b0;
        w_rdy_g     = 1'b0;
        w_hs        = 1'b0;
        w_burst_end = 1'b0;
        if (!USER_SESSION_ESTABLISHED) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!USER_TX_AFULL && (|REQ_VALID)) begin
                        w_grant_en  = 1'b1;
                        w_state_nxt = S_HDR;
                    end
                end
                S_HDR: begin
                    if (!USER_TX_AFULL) begin
                        w_emit_hdr  = 1'b1;
                        w_state_nxt = S_DATA;
                    end
                end
                S_DATA: begin
                    w_rdy_g = !USER_TX_AFULL;
                    if (!USER_TX_AFULL && w_g_valid) begin
                        w_hs = 1'b1;
                        if (w_g_last || (w_wcnt_inc >= C_BURST)) begin
                            w_burst_end = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Only the granted channel sees READY; it follows AFULL combinationally.
    always_comb begin
        REQ_READY = '0;
        for (int j = 0; j < NCH; j++) begin
            REQ_READY[j] = w_rdy_g && (r_grant == 4'(j));
        end
    end

    // FSM state register.
    always_ff @(posedge XGMII_CLOCK) begin
        if (RSTs) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant, pointer, word counter and registered transmit outputs.
    always_ff @(posedge XGMII_CLOCK) begin
        if (RSTs) begin
            r_ptr   <= 4'd0;
            r_grant <= 4'd0;
            r_wcnt  <= 17'd0;
            r_tx_d  <= 64'd0;
            r_tx_b  <= 4'd0;
        end else begin
            r_tx_b <= 4'd0;
            if (!USER_SESSION_ESTABLISHED) begin
                r_ptr <= 4'd0;
            end else begin
                if (w_grant_en) begin
                    r_grant <= w_pick;
                    r_wcnt  <= 17'd0;
                end
                if (w_emit_hdr) begin
                    r_tx_d <= w_hdr;
                    r_tx_b <= 4'd8;
                end
                if (w_hs) begin
                    r_tx_d <= w_g_d;
                    r_tx_b <= w_b_clamp;
                    r_wcnt <= w_wcnt_inc;
                end
                if (w_burst_end) begin
                    r_ptr <= w_ptr_nxt;
                end
            end
        end
    end

    // Per-channel header sequence numbers; cleared whenever the session is down.
    always_ff @(posedge XGMII_CLOCK) begin
        if (RSTs || !USER_SESSION_ESTABLISHED) begin
            for (int j = 0; j < NCH; j++) begin
                r_seq[j] <= 32'd0;
            end
        end else if (w_emit_hdr) begin
            for (int j = 0; j < NCH; j++) begin
                if (r_grant == 4'(j)) begin
                    r_seq[j] <= r_seq[j] + 32'd1;
                end
            end
        end
    end

    assign USER_TX_D = r_tx_d;
    assign USER_TX_B = r_tx_b;
    assign GRANT_CH  = r_grant;
    assign BUSY      = (r_state != S_IDLE);

endmodule

// File: tb/tb_sitcpxg_tx_arbiter.sv
// tb/tb_sitcpxg_tx_arbiter.sv - self-checking bench for sitcpxg_tx_arbiter
module tb_sitcpxg_tx_arbiter;

    localparam int NCH   = 4;
    localparam int BW    = 4;
    localparam int DEPTH = 256;

    logic               clk = 1'b0;
    logic               rst;
    logic               est;
    logic               afull;
    logic [63:0]        tx_d;
    logic [3:0]         tx_b;
    logic [NCH-1:0]     req_valid;
    logic [NCH*64-1:0]  req_d;
    logic [NCH*4-1:0]   req_b;
    logic [NCH-1:0]     req_last;
    logic [NCH-1:0]     req_ready;
    logic [3:0]         grant_ch;
    logic               busy;

    always #5 clk = ~clk;

    sitcpxg_tx_arbiter #(.NCH(NCH), .BURST_WORDS(BW)) dut (
        .XGMII_CLOCK              (clk),
        .RSTs                     (rst),
        .USER_SESSION_ESTABLISHED (est),
        .USER_TX_AFULL            (afull),
        .USER_TX_D                (tx_d),
        .USER_TX_B                (tx_b),
        .REQ_VALID                (req_valid),
        .REQ_D                    (req_d),
        .REQ_B                    (req_b),
        .REQ_LAST                 (req_last),
        .REQ_READY                (req_ready),
        .GRANT_CH                 (grant_ch),
        .BUSY                     (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Per-channel word sources
    logic [63:0] src_d    [NCH][DEPTH];
    logic [3:0]  src_b    [NCH][DEPTH];
    logic        src_last [NCH][DEPTH];
    int          len     [NCH];
    int          idx     [NCH];

    // Stream model: what the host should see on USER_TX_D/B
    int          exp_idx [NCH];
    logic [31:0] mseq    [NCH];
    bit          in_burst;
    int          cur;
    int          nwords;
    int          rr_next;
    bit          rr_on;
    int          cyc;
    logic [31:0] last_hdr_seq;
    int          hdr_ch_q  [$];
    int          hdr_cyc_q [$];

    function automatic logic [3:0] clamp(input logic [3:0] b);
        return (b > 4'd8) ? 4'd8 : b;
    endfunction

    task automatic set_src(input int c, input int n, input int last_mod, input bit rnd);
        for (int k = 0; k < n; k++) begin
            if (rnd) begin
                src_d[c][k]    = {$urandom, $urandom};
                src_b[c][k]    = 4'($urandom_range(15));
                src_last[c][k] = ($urandom_range(3) == 0);
            end else begin
                src_d[c][k]    = {16'hDA7A, c[15:0], k[31:0]};
                src_b[c][k]    = 4'd8;
                src_last[c][k] = (last_mod > 0) && ((k % last_mod) == last_mod - 1);
            end
        end
        len[c]     = n;
        idx[c]     = 0;
        exp_idx[c] = 0;
    endtask

    task automatic model_reset();
        in_burst = 1'b0;
        rr_next  = 0;
        nwords   = 0;
        for (int c = 0; c < NCH; c++) begin
            mseq[c]    = 32'd0;
            exp_idx[c] = idx[c];
        end
    endtask

    task automatic advance();
        logic lw;
        lw = src_last[cur][exp_idx[cur]];
        exp_idx[cur]++;
        nwords++;
        if (lw || nwords >= BW) in_burst = 1'b0;
    endtask

    task automatic monitor();
        int ch;
        if (tx_b != 4'd0) begin
            while (in_burst && exp_idx[cur] < len[cur] && src_b[cur][exp_idx[cur]] == 4'd0) advance();
            if (!in_burst) begin
                check("hdr_b", 64'(tx_b), 64'd8);
                check("hdr_tag", {40'd0, tx_d[63:56], tx_d[47:32]}, {40'd0, 8'hC3, 16'h0000});
                ch = int'(tx_d[55:48]);
                check("hdr_ch_range", 64'(ch < NCH), 64'd1);
                if (ch < NCH) begin
                    if (rr_on) check("hdr_rr", 64'(ch), 64'(rr_next));
                    check("hdr_seq", 64'(tx_d[31:0]), 64'(mseq[ch]));
                    last_hdr_seq = tx_d[31:0];
                    mseq[ch]++;
                    rr_next  = (ch + 1) % NCH;
                    in_burst = 1'b1;
                    cur      = ch;
                    nwords   = 0;
                    hdr_ch_q.push_back(ch);
                    hdr_cyc_q.push_back(cyc);
                end
            end else begin
                check("data_idx", 64'(exp_idx[cur] < len[cur]), 64'd1);
                if (exp_idx[cur] < len[cur]) begin
                    check("data_d", tx_d, src_d[cur][exp_idx[cur]]);
                    check("data_b", 64'(tx_b), 64'(clamp(src_b[cur][exp_idx[cur]])));
                    advance();
                end
            end
        end
    endtask

    task automatic tick();
        logic [NCH-1:0]    v, l, hs;
        logic [NCH*64-1:0] d;
        logic [NCH*4-1:0]  b;
        v = '0; l = '0; d = '0; b = '0;
        for (int c = 0; c < NCH; c++) begin
            if (idx[c] < len[c]) begin
                v[c]         = 1'b1;
                d[c*64 +: 64] = src_d[c][idx[c]];
                b[c*4 +: 4]  = src_b[c][idx[c]];
                l[c]         = src_last[c][idx[c]];
            end
        end
        req_valid = v;
        req_d     = d;
        req_b     = b;
        req_last  = l;
        #1;
        if (afull) check("ready_afull", 64'(req_ready), 64'd0);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < NCH; c++) begin
            if (hs[c]) idx[c]++;
        end
        monitor();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        for (int c = 0; c < NCH; c++) begin
            len[c] = 0;
            idx[c] = 0;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic [3:0]  b;
        logic        l;
        logic        exp_busy;
        logic        exp_rdy;
        logic [3:0]  exp_txb;
        logic [63:0] exp_txd;
    } vec_t;

    vec_t tv [12];

    function automatic vec_t mk(input logic v, input logic [63:0] d, input logic [3:0] b, input logic l,
                                input logic eb, input logic er, input logic [3:0] etb, input logic [63:0] etd);
        vec_t r;
        r.v = v; r.d = d; r.b = b; r.l = l;
        r.exp_busy = eb; r.exp_rdy = er; r.exp_txb = etb; r.exp_txd = etd;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] w0, w1, w2;
        bit          done;
        int          n0;
        int          nh;

        w0 = 64'h0011223344556677;
        w1 = 64'h8899AABBCCDDEEFF;
        w2 = 64'h0123456789ABCDEF;

        rst = 1'b1; est = 1'b1; afull = 1'b0;
        req_valid = '0; req_d = '0; req_b = '0; req_last = '0;
        cyc = 0; rr_on = 1'b0; cur = 0; last_hdr_seq = 32'd0;
        for (int c = 0; c < NCH; c++) begin
            len[c] = 0; idx[c] = 0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd",   tx_d, 64'd0);
        check("rst_txb",   64'(tx_b), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_grant", 64'(grant_ch), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        rst = 1'b0;

        // Two identical channel-0 bursts of three words
        for (int r = 0; r < 2; r++) begin
            tv[r*6+0] = mk(1'b1, w0, 4'd8, 1'b0, 1'b0, 1'b0, 4'd0, 64'd0);
            tv[r*6+1] = mk(1'b1, w0, 4'd8, 1'b0, 1'b1, 1'b0, 4'd8, {32'hC3000000, 32'(r)});
            tv[r*6+2] = mk(1'b1, w0, 4'd8, 1'b0, 1'b1, 1'b1, 4'd8, w0);
            tv[r*6+3] = mk(1'b1, w1, 4'd8, 1'b0, 1'b1, 1'b1, 4'd8, w1);
            tv[r*6+4] = mk(1'b1, w2, 4'd5, 1'b1, 1'b1, 1'b1, 4'd5, w2);
            tv[r*6+5] = mk(1'b0, 64'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 64'd0);
        end
        for (int i = 0; i < 12; i++) begin
            req_valid = {{(NCH-1){1'b0}}, tv[i].v};
            req_d     = {{((NCH-1)*64){1'b0}}, tv[i].d};
            req_b     = {{((NCH-1)*4){1'b0}}, tv[i].b};
            req_last  = {{(NCH-1){1'b0}}, tv[i].l};
            #1;
            check("tbl_busy",  64'(busy), 64'(tv[i].exp_busy));
            check("tbl_ready", 64'(req_ready), 64'({{(NCH-1){1'b0}}, tv[i].exp_rdy}));
            @(posedge clk);
            #1;
            check("tbl_txb", 64'(tx_b), 64'(tv[i].exp_txb));
            if (tv[i].exp_txb != 4'd0) check("tbl_txd", tx_d, tv[i].exp_txd);
        end

        // All four channels continuously valid, bursts capped at BW words
        do_reset();
        for (int c = 0; c < NCH; c++) set_src(c, 8, 0, 1'b0);
        rr_on = 1'b1;
        n0 = hdr_ch_q.size();
        repeat (60) tick();
        rr_on = 1'b0;
        nh = hdr_ch_q.size() - n0;
        check("rr_hdr_count", 64'(nh), 64'd8);
        for (int i = 0; i < nh && i < 8; i++) begin
            check("rr_order", 64'(hdr_ch_q[n0+i]), 64'(i % NCH));
            if (i > 0) check("rr_gap", 64'(hdr_cyc_q[n0+i] - hdr_cyc_q[n0+i-1]), 64'(BW + 2));
        end
        for (int c = 0; c < NCH; c++) check("rr_words", 64'(exp_idx[c]), 64'd8);

        // AFULL held for five cycles in the middle of a channel-2 burst
        set_src(2, 4, 4, 1'b0);
        src_b[2][1] = 4'd3;
        src_b[2][2] = 4'd15;
        done = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (idx[2] == 2 && !done) begin
                afull = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    check("afull_txb", 64'(tx_b), 64'd0);
                end
                afull = 1'b0;
                done  = 1'b1;
            end else begin
                tick();
            end
        end
        check("afull_reached", 64'(done), 64'd1);
        check("afull_words", 64'(exp_idx[2]), 64'd4);

        // Session drops after two data words of a channel-3 burst
        set_src(3, 4, 4, 1'b0);
        done = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (idx[3] == 2 && !done) begin
                est = 1'b0;
                tick();
                check("est_busy", 64'(busy), 64'd0);
                check("est_txb", 64'(tx_b), 64'd0);
                model_reset();
                tick();
                tick();
                est  = 1'b1;
                done = 1'b1;
            end else begin
                tick();
            end
        end
        check("est_reached", 64'(done), 64'd1);
        check("est_words", 64'(exp_idx[3]), 64'd4);
        check("est_seq0", 64'(last_hdr_seq), 64'd0);

        // Reset pulsed while the second grant is in HDR
        set_src(0, 4, 2, 1'b0);
        set_src(1, 4, 4, 1'b0);
        done = 1'b0;
        n0 = 0;
        for (int t = 0; t < 40; t++) begin
            if (idx[0] == 2 && !done) begin
                tick();
                check("rst_in_hdr", 64'(busy), 64'd1);
                rst = 1'b1;
                tick();
                check("rsth_txd",   tx_d, 64'd0);
                check("rsth_txb",   64'(tx_b), 64'd0);
                check("rsth_grant", 64'(grant_ch), 64'd0);
                check("rsth_busy",  64'(busy), 64'd0);
                check("rsth_ready", 64'(req_ready), 64'd0);
                rst = 1'b0;
                model_reset();
                n0   = hdr_ch_q.size();
                done = 1'b1;
            end else begin
                tick();
            end
        end
        check("rsth_reached", 64'(done), 64'd1);
        check("rsth_hdr_seen", 64'(hdr_ch_q.size() > n0), 64'd1);
        if (hdr_ch_q.size() > n0) check("rsth_first_grant", 64'(hdr_ch_q[n0]), 64'd0);

        // Randomized traffic on all channels against the stream model
        do_reset();
        for (int c = 0; c < NCH; c++) set_src(c, DEPTH, 0, 1'b1);
        rr_on = 1'b1;
        n0 = hdr_ch_q.size();
        for (int t = 0; t < 600; t++) begin
            bit drop;
            afull = ($urandom_range(3) == 0);
            drop  = ($urandom_range(49) == 0);
            est   = !drop;
            tick();
            if (drop) model_reset();
        end
        est = 1'b1;
        afull = 1'b0;
        rr_on = 1'b0;
        check("rand_progress", 64'(hdr_ch_q.size() - n0 > 20), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
